gf180mcu_fd_sc_mcu7t5v0__comb4_bist: RTL and testbench

//  On-chip stimulus/response engine for 4-input combinational cells on test chips.

---
 rtl/gf180mcu_fd_sc_mcu7t5v0__comb4_bist.sv | 175 +++++++++++++++++
 tb/tb_gf180mcu_fd_sc_mcu7t5v0__comb4_bist.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/gf180mcu_fd_sc_mcu7t5v0__comb4_bist.sv
// Built-in self-test engine for a 4-input combinational standard cell.
// The engine walks all 16 input vectors {C,B,A2,A1} onto the cell-under-test.
// It waits SETTLE_CYC cycles for each vector to settle, then samples ZN once.
// Each sample is checked against the TRUTH table.
//
// Ports:
//   CLK        rising-edge clock
//   RST        asynchronous active-high reset
//   START      run request, accepted in IDLE or DONE
//   GRAY       vector order select (0 binary, 1 Gray), latched with START
//   A1,A2,B,C  drives to the cell-under-test (vector bits 0..3)
//   ZN         response from the cell-under-test
//   BUSY       run in progress
//   DONE       run complete, held until the next accepted START
//   PASS       DONE with zero mismatches
//   ERR_CNT    mismatch count, 0..16
//   FAIL_VEC   vector of the first mismatch (valid when FAIL_SEEN)
//   FAIL_SEEN  at least one mismatch in the current/last run
module gf180mcu_fd_sc_mcu7t5v0__comb4_bist #(
  parameter logic [15:0] TRUTH      = 16'h1FFF,
  parameter int unsigned SETTLE_CYC = 2
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       START,
  input  logic       GRAY,
  output logic       A1,
  output logic       A2,
  output logic       B,
  output logic       C,
  input  logic       ZN,
  output logic       BUSY,
  output logic       DONE,
  output logic       PASS,
  output logic [4:0] ERR_CNT,
  output logic [3:0] FAIL_VEC,
  output logic       FAIL_SEEN
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETTLE = 2'd1,
    S_SAMPLE = 2'd2,
    S_DONE   = 2'd3
  } state_e;

  // Last value of the settle counter before moving to SAMPLE.
  localparam logic [3:0] SETTLE_LAST = 4'((SETTLE_CYC == 0) ? 0 : SETTLE_CYC - 1);
  // State entered after a vector is driven. SETTLE is skipped when there is no settle time.
  localparam state_e AFTER_DRIVE = (SETTLE_CYC == 0) ? S_SAMPLE : S_SETTLE;

  state_e     state_q, state_d;
  logic [3:0] step_q, step_d;
  logic [3:0] cnt_q, cnt_d;
  logic       gray_q, gray_d;
  logic [3:0] pins_q, pins_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       pass_q, pass_d;
  logic [4:0] err_q, err_d;
  logic [3:0] fvec_q, fvec_d;
  logic       fseen_q, fseen_d;

  logic       exp_bit;
  logic       mism;
  logic [4:0] err_inc;

  function automatic logic [3:0] vec_of(input logic [3:0] s, input logic g);
    return g ? (s ^ (s >> 1)) : s;
  endfunction

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= S_IDLE;
      step_q  <= '0;
      cnt_q   <= '0;
      gray_q  <= 1'b0;
      pins_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      err_q   <= '0;
      fvec_q  <= '0;
      fseen_q <= 1'b0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      cnt_q   <= cnt_d;
      gray_q  <= gray_d;
      pins_q  <= pins_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
      err_q   <= err_d;
      fvec_q  <= fvec_d;
      fseen_q <= fseen_d;
    end
  end

  // pins_q always holds vec(step_q) while running, so it indexes the truth table directly.
  // Case inequality makes an X or Z response count as a mismatch.
  assign exp_bit = TRUTH[pins_q];
  assign mism    = (ZN !== exp_bit);
  assign err_inc = err_q + {4'd0, mism};

  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    cnt_d   = cnt_q;
    gray_d  = gray_q;
    pins_d  = pins_q;
    busy_d  = busy_q;
    done_d  = done_q;
    pass_d  = pass_q;
    err_d   = err_q;
    fvec_d  = fvec_q;
    fseen_d = fseen_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (START) begin
          gray_d  = GRAY;
          step_d  = '0;
          cnt_d   = '0;
          pins_d  = vec_of(4'd0, GRAY);
          busy_d  = 1'b1;
          done_d  = 1'b0;
          pass_d  = 1'b0;
          err_d   = '0;
          fvec_d  = '0;
          fseen_d = 1'b0;
          state_d = AFTER_DRIVE;
        end
      end
      S_SETTLE: begin
        if (cnt_q == SETTLE_LAST) begin
          cnt_d   = '0;
          state_d = S_SAMPLE;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      S_SAMPLE: begin
        err_d = err_inc;
        if (mism && !fseen_q) begin
          fvec_d  = pins_q;
          fseen_d = 1'b1;
        end
        if (step_q != 4'd15) begin
          step_d  = step_q + 4'd1;
          pins_d  = vec_of(step_q + 4'd1, gray_q);
          state_d = AFTER_DRIVE;
        end else begin
          busy_d  = 1'b0;
          done_d  = 1'b1;
          pass_d  = (err_inc == 5'd0);
          state_d = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign A1        = pins_q[0];
  assign A2        = pins_q[1];
  assign B         = pins_q[2];
  assign C         = pins_q[3];
  assign BUSY      = busy_q;
  assign DONE      = done_q;
  assign PASS      = pass_q;
  assign ERR_CNT   = err_q;
  assign FAIL_VEC  = fvec_q;
  assign FAIL_SEEN = fseen_q;

endmodule

// File: tb/tb_gf180mcu_fd_sc_mcu7t5v0__comb4_bist.sv
// Directed bench for the comb4 BIST engine.
// Instance dut uses SETTLE_CYC=2 and instance dut0 uses SETTLE_CYC=0.
// Each instance drives a behavioural cell model selected by a mode variable.
module tb_gf180mcu_fd_sc_mcu7t5v0__comb4_bist;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // Instance with SETTLE_CYC=2
  logic       start = 1'b0, gray = 1'b0, zn;
  logic       a1, a2, b, c, busy, done, pass, fseen;
  logic [4:0] err;
  logic [3:0] fvec;
  int         mode = 0;

  // Instance with SETTLE_CYC=0
  logic       start0 = 1'b0, gray0 = 1'b0, zn0;
  logic       a1_0, a2_0, b_0, c_0, busy0, done0, pass0, fseen0;
  logic [4:0] err0;
  logic [3:0] fvec0;
  int         mode0 = 0;

  logic zx;

  int asserts = 0;
  int fails   = 0;

  gf180mcu_fd_sc_mcu7t5v0__comb4_bist #(.TRUTH(16'h1FFF), .SETTLE_CYC(2)) dut (
    .CLK(clk), .RST(rst), .START(start), .GRAY(gray),
    .A1(a1), .A2(a2), .B(b), .C(c), .ZN(zn),
    .BUSY(busy), .DONE(done), .PASS(pass),
    .ERR_CNT(err), .FAIL_VEC(fvec), .FAIL_SEEN(fseen)
  );

  gf180mcu_fd_sc_mcu7t5v0__comb4_bist #(.TRUTH(16'h1FFF), .SETTLE_CYC(0)) dut0 (
    .CLK(clk), .RST(rst), .START(start0), .GRAY(gray0),
    .A1(a1_0), .A2(a2_0), .B(b_0), .C(c_0), .ZN(zn0),
    .BUSY(busy0), .DONE(done0), .PASS(pass0),
    .ERR_CNT(err0), .FAIL_VEC(fvec0), .FAIL_SEEN(fseen0)
  );

  // Cell models: 0 ideal oai211, 1 stuck-at-1, 2 stuck-at-0, 3 ideal except X at vector 6
  always_comb begin
    zn = ~((a1 | a2) & b & c);
    case (mode)
      1: zn = 1'b1;
      2: zn = 1'b0;
      3: if ({c, b, a2, a1} == 4'd6) zn = zx;
      default: ;
    endcase
  end

  always_comb begin
    zn0 = ~((a1_0 | a2_0) & b_0 & c_0);
    case (mode0)
      1: zn0 = 1'b1;
      2: zn0 = 1'b0;
      default: ;
    endcase
  end

  task automatic pulse_start(input bit which);
    @(posedge clk); #1;
    if (which) start0 = 1'b1; else start = 1'b1;
    @(posedge clk); #1;
    if (which) start0 = 1'b0; else start = 1'b0;
  endtask

  // Counts edges after the accepting edge until DONE is seen, bounded.
  task automatic wait_done(input bit which, output int cyc);
    cyc = 0;
    while (((which ? done0 : done) !== 1'b1) && cyc < 200) begin
      @(posedge clk); #1;
      cyc++;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    asserts++;
    if ({a1, a2, b, c, busy, done, pass, err, fvec, fseen} !== 17'd0) begin
      fails++;
      $display("FAIL reset_dut got=%h want=0", {a1, a2, b, c, busy, done, pass, err, fvec, fseen});
    end
    asserts++;
    if ({a1_0, a2_0, b_0, c_0, busy0, done0, pass0, err0, fvec0, fseen0} !== 17'd0) begin
      fails++;
      $display("FAIL reset_dut0 got=%h want=0", {a1_0, a2_0, b_0, c_0, busy0, done0, pass0, err0, fvec0, fseen0});
    end
    rst = 1'b0;
  endtask

  task automatic test_ideal;
    int cyc;
    mode = 0; gray = 1'b0;
    pulse_start(1'b0);
    asserts++;
    if (busy !== 1'b1) begin fails++; $display("FAIL ideal_busy got=%b want=1", busy); end
    wait_done(1'b0, cyc);
    asserts++;
    if (cyc != 48) begin fails++; $display("FAIL ideal_latency got=%0d want=48", cyc); end
    asserts++;
    if ({busy, done, pass, err, fseen} !== {1'b0, 1'b1, 1'b1, 5'd0, 1'b0}) begin
      fails++;
      $display("FAIL ideal_result busy=%b done=%b pass=%b err=%0d fseen=%b want 0 1 1 0 0", busy, done, pass, err, fseen);
    end
  endtask

  task automatic test_stuck1;
    int cyc;
    mode = 1; gray = 1'b0;
    pulse_start(1'b0);
    wait_done(1'b0, cyc);
    asserts++;
    if ({err, fvec, fseen, pass} !== {5'd3, 4'd13, 1'b1, 1'b0}) begin
      fails++;
      $display("FAIL stuck1 err=%0d fvec=%0d fseen=%b pass=%b want 3 13 1 0", err, fvec, fseen, pass);
    end
  endtask

  task automatic test_gray_stuck0;
    int seq [16] = '{0, 1, 3, 2, 6, 7, 5, 4, 12, 13, 15, 14, 10, 11, 9, 8};
    mode = 2; gray = 1'b1;
    pulse_start(1'b0);
    gray = 1'b0;  // mid-run change must not alter the order
    for (int cc = 0; cc < 48; cc++) begin
      if (cc % 3 == 0) begin
        asserts++;
        if ({c, b, a2, a1} !== 4'(seq[cc / 3])) begin
          fails++;
          $display("FAIL gray_pins idx=%0d got=%0d want=%0d", cc / 3, {c, b, a2, a1}, seq[cc / 3]);
        end
      end
      @(posedge clk); #1;
    end
    asserts++;
    if ({done, err, fvec, fseen, pass} !== {1'b1, 5'd13, 4'd0, 1'b1, 1'b0}) begin
      fails++;
      $display("FAIL gray_stuck0 done=%b err=%0d fvec=%0d fseen=%b pass=%b want 1 13 0 1 0", done, err, fvec, fseen, pass);
    end
  endtask

  task automatic test_settle0;
    int cyc;
    mode0 = 1;
    pulse_start(1'b1);
    wait_done(1'b1, cyc);
    asserts++;
    if (cyc != 16) begin fails++; $display("FAIL s0_latency1 got=%0d want=16", cyc); end
    asserts++;
    if ({err0, fvec0, pass0} !== {5'd3, 4'd13, 1'b0}) begin
      fails++;
      $display("FAIL s0_run1 err=%0d fvec=%0d pass=%b want 3 13 0", err0, fvec0, pass0);
    end
    mode0 = 0;
    pulse_start(1'b1);
    asserts++;
    if ({busy0, done0, pass0, err0, fseen0} !== {1'b1, 1'b0, 1'b0, 5'd0, 1'b0}) begin
      fails++;
      $display("FAIL s0_clear busy=%b done=%b pass=%b err=%0d fseen=%b want 1 0 0 0 0", busy0, done0, pass0, err0, fseen0);
    end
    wait_done(1'b1, cyc);
    asserts++;
    if (cyc != 16 || pass0 !== 1'b1 || err0 !== 5'd0) begin
      fails++;
      $display("FAIL s0_run2 cyc=%0d pass=%b err=%0d want 16 1 0", cyc, pass0, err0);
    end
  endtask

  task automatic test_back_to_back_start;
    int cc;
    mode = 0; gray = 1'b0;
    pulse_start(1'b0);
    cc = 0;
    while (done !== 1'b1 && cc < 200) begin
      @(posedge clk); #1;
      cc++;
      if (cc == 16) begin
        asserts++;
        if ({c, b, a2, a1} !== 4'd5) begin fails++; $display("FAIL ignore_step got=%0d want=5", {c, b, a2, a1}); end
        start = 1'b1;
      end
      if (cc == 17) start = 1'b0;
    end
    asserts++;
    if (cc != 48 || pass !== 1'b1) begin
      fails++;
      $display("FAIL ignore_start cyc=%0d pass=%b want 48 1", cc, pass);
    end
  endtask

  task automatic test_rst_mid;
    pulse_start(1'b0);
    repeat (22) @(posedge clk);
    #1;
    asserts++;
    if ({c, b, a2, a1} !== 4'd7 || busy !== 1'b1) begin
      fails++;
      $display("FAIL rst_pre pins=%0d busy=%b want 7 1", {c, b, a2, a1}, busy);
    end
    #2 rst = 1'b1;
    #1;
    asserts++;
    if ({a1, a2, b, c, busy, done, pass, err, fvec, fseen} !== 17'd0) begin
      fails++;
      $display("FAIL rst_async got=%h want=0", {a1, a2, b, c, busy, done, pass, err, fvec, fseen});
    end
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    asserts++;
    if ({busy, done, c, b, a2, a1} !== 6'd0) begin
      fails++;
      $display("FAIL rst_idle busy=%b done=%b pins=%0d want 0 0 0", busy, done, {c, b, a2, a1});
    end
  endtask

  task automatic test_x_zn;
    int  cyc;
    bit  exp_mis;
    zx = 1'bx;
    // Whatever value the simulator gives the X response, it is a mismatch unless it reads as 1.
    exp_mis = (zx !== 1'b1);
    mode = 3; gray = 1'b0;
    pulse_start(1'b0);
    wait_done(1'b0, cyc);
    asserts++;
    if (err !== {4'd0, exp_mis} || fseen !== exp_mis) begin
      fails++;
      $display("FAIL xzn_count err=%0d fseen=%b want %0d %b", err, fseen, exp_mis, exp_mis);
    end
    if (exp_mis) begin
      asserts++;
      if (fvec !== 4'd6 || pass !== 1'b0) begin
        fails++;
        $display("FAIL xzn_vec fvec=%0d pass=%b want 6 0", fvec, pass);
      end
    end
  endtask

  initial begin
    test_reset();
    test_ideal();
    test_stuck1();
    test_gray_stuck0();
    test_settle0();
    test_back_to_back_start();
    test_rst_mid();
    test_x_zn();
    $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
    $finish;
  end

endmodule
